// File: rtl/lva_arbiter.sv
// Two-requester arbiter for the single local variable array port: turns frame-relative
// indices into absolute addresses, bounds-checks them and runs the LVA trigger/done handshake.
`timescale 1ns/1ps
module lva_arbiter #(
  parameter int LVA_SIZE = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(LVA_SIZE)-1:0] frame_base,
  input  logic                        a_trigger,
  input  logic                        a_write,
  input  logic [$clog2(LVA_SIZE)-1:0] a_index,
  input  logic [31:0]                 a_wdata,
  output logic [31:0]                 a_rdata,
  output logic                        a_done,
  output logic                        a_err,
  output logic                        a_busy,
  input  logic                        b_trigger,
  input  logic                        b_write,
  input  logic [$clog2(LVA_SIZE)-1:0] b_index,
  input  logic [31:0]                 b_wdata,
  output logic [31:0]                 b_rdata,
  output logic                        b_done,
  output logic                        b_err,
  output logic                        b_busy,
  output logic                        lva_trigger,
  output logic                        lva_write,
  output logic [$clog2(LVA_SIZE)-1:0] lva_addr,
  output logic [31:0]                 lva_wdata,
  input  logic [31:0]                 lva_rdata,
  input  logic                        lva_done
);
  localparam int ADDR = $clog2(LVA_SIZE);
  localparam logic [ADDR:0] LIMIT = (ADDR+1)'(LVA_SIZE);

  // Requesters: pulse x_trigger while x_busy = 0 to post a request; one x_done
  // pulse (with x_err if out of range) ends it. LVA: lva_trigger is a one-cycle
  // start pulse, addr/write/wdata stay stable until the lva_done pulse.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_next;

  logic            a_pend, b_pend;
  logic            a_wr_q, b_wr_q;
  logic [ADDR-1:0] a_idx_q, b_idx_q;
  logic [31:0]     a_wd_q, b_wd_q;
  logic            last_b;   // 1 = B was granted last
  logic            gnt_b;    // requester currently in service
  logic            err_q;

  logic            pick_b;
  logic [ADDR-1:0] sel_idx;
  logic [ADDR:0]   abs_addr;
  logic            oor;

  always_comb begin
    pick_b   = b_pend & (~a_pend | ~last_b);
    sel_idx  = pick_b ? b_idx_q : a_idx_q;
    abs_addr = {1'b0, frame_base} + {1'b0, sel_idx};
    oor      = (abs_addr >= LIMIT);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (a_pend | b_pend) state_next = oor ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (lva_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_pend    <= 1'b0;
      b_pend    <= 1'b0;
      a_wr_q    <= 1'b0;
      b_wr_q    <= 1'b0;
      a_idx_q   <= '0;
      b_idx_q   <= '0;
      a_wd_q    <= '0;
      b_wd_q    <= '0;
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      err_q     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      lva_write <= 1'b0;
      lva_addr  <= '0;
      lva_wdata <= '0;
    end else begin
      state <= state_next;
      if (a_trigger && !a_pend) begin
        a_pend  <= 1'b1;
        a_wr_q  <= a_write;
        a_idx_q <= a_index;
        a_wd_q  <= a_wdata;
      end
      if (b_trigger && !b_pend) begin
        b_pend  <= 1'b1;
        b_wr_q  <= b_write;
        b_idx_q <= b_index;
        b_wd_q  <= b_wdata;
      end
      case (state)
        IDLE: begin
          if (a_pend || b_pend) begin
            gnt_b  <= pick_b;
            last_b <= pick_b;
            err_q  <= oor;
            if (!oor) begin
              lva_addr  <= abs_addr[ADDR-1:0];
              lva_wdata <= pick_b ? b_wd_q : a_wd_q;
              lva_write <= pick_b ? b_wr_q : a_wr_q;
            end
          end
        end
        WAIT: begin
          if (lva_done) begin
            lva_write <= 1'b0;
            // lva_write still tells load from store during this cycle
            if (!lva_write) begin
              if (gnt_b) b_rdata <= lva_rdata;
              else       a_rdata <= lva_rdata;
            end
          end
        end
        RESP: begin
          if (gnt_b) b_pend <= 1'b0;
          else       a_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lva_trigger = (state == ISSUE);
    a_done      = (state == RESP) & ~gnt_b;
    b_done      = (state == RESP) &  gnt_b;
    a_err       = a_done & err_q;
    b_err       = b_done & err_q;
    a_busy      = a_pend;
    b_busy      = b_pend;
  end
endmodule
